// File: rtl/single_port_mem_ctrl.sv
// single_port_mem_ctrl: valid/ready request stream to single-port memory select/enable/tristate-bus sequencing.
// Optional read-modify-write byte-strobe support is enabled by defining SPM_CTRL_RMW_EN.
module single_port_mem_ctrl #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [AddrWidth-1:0]   req_addr,
    input  logic [DataWidth-1:0]   req_wdata,
`ifdef SPM_CTRL_RMW_EN
    input  logic [DataWidth/8-1:0] req_wstrb,
`endif
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DataWidth-1:0]   rsp_rdata,
    output logic                   mem_clk,
    output logic                   mem_select,
    output logic                   mem_o_enable,
    output logic                   mem_w_enable,
    output logic [AddrWidth-1:0]   mem_addr,
    inout  wire  [DataWidth-1:0]   mem_data
);
    typedef enum logic [2:0] {
        IDLE, WRITE, RD_ADDR, RD_DATA
`ifdef SPM_CTRL_RMW_EN
        , RMW_DATA
`endif
    } state_t;
    state_t state, state_nxt;
    logic accept;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q, wr_word;
`ifdef SPM_CTRL_RMW_EN
    logic rmw_req, rmw_q;
    logic [DataWidth/8-1:0] strb_q;
    logic [DataWidth-1:0] merge_q;
    assign rmw_req = req_write & ~&req_wstrb;
    // a partial write must not start while a response is still waiting
    assign req_ready = rst_n & (state == IDLE) & (!rsp_valid | rsp_ready) & !(rmw_req & rsp_valid);
`else
    assign req_ready = rst_n & (state == IDLE) & (!rsp_valid | rsp_ready);
`endif
    assign accept = req_valid & req_ready;
    assign mem_clk = clk;
    assign mem_addr = addr_q;
    assign mem_data = mem_w_enable ? wr_word : {DataWidth{1'bz}};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        unique case (state)
`ifdef SPM_CTRL_RMW_EN
            IDLE:     if (accept) state_nxt = (req_write & !rmw_req) ? WRITE : RD_ADDR;
            RD_ADDR:  state_nxt = rmw_q ? RMW_DATA : RD_DATA;
            RMW_DATA: state_nxt = WRITE;
`else
            IDLE:     if (accept) state_nxt = req_write ? WRITE : RD_ADDR;
            RD_ADDR:  state_nxt = RD_DATA;
`endif
            RD_DATA:  state_nxt = IDLE;
            WRITE:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
    always_comb begin
        mem_select   = state != IDLE;
        mem_w_enable = state == WRITE;
`ifdef SPM_CTRL_RMW_EN
        mem_o_enable = (state == RD_DATA) || (state == RMW_DATA);
`else
        mem_o_enable = state == RD_DATA;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef SPM_CTRL_RMW_EN
            strb_q  <= '0;
            rmw_q   <= 1'b0;
`endif
        end else if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef SPM_CTRL_RMW_EN
            strb_q  <= req_wstrb;
            rmw_q   <= rmw_req;
`endif
        end
    end
`ifdef SPM_CTRL_RMW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) merge_q <= '0;
        else if (state == RMW_DATA) merge_q <= mem_data;
    end
    always_comb begin
        wr_word = wdata_q;
        for (int i = 0; i < DataWidth/8; i++)
            if (!strb_q[i]) wr_word[8*i +: 8] = merge_q[8*i +: 8];
    end
`else
    assign wr_word = wdata_q;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (state == RD_DATA) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_data;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule
